// File: rtl/serializer_arbiter.sv
// Round-robin transmit scheduler: shares one serializer between N_CH
// requesters, holds the granted word, pulses new-data once, then follows
// the serializer's ready line through busy and back to idle.
module serializer_arbiter #(
  parameter int N_CH       = 4,
  parameter int TXN_SZ     = 8,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 4,
  localparam int GW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*TXN_SZ-1:0]   data,
  output logic [N_CH-1:0]          ack,
  output logic [TXN_SZ-1:0]        ser_data,
  output logic                     ser_nd,
  input  logic                     ser_rdy,
  output logic [GW-1:0]            grant_id,
  output logic                     busy,
  output logic                     err
);

  // One counter serves both the handshake timeout and the inter-frame gap,
  // so it is sized for whichever reload value is larger.
  localparam int CMAX     = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CW       = (CMAX > 1) ? $clog2(CMAX + 1) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [GW-1:0]       ptr;
  logic [CW-1:0]       cnt;
  logic                win_valid;
  logic [GW-1:0]       win_id;
  logic [TXN_SZ-1:0]   words [N_CH];

  // Unpack the flat data bus into one word per channel.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      words[i] = data[i*TXN_SZ +: TXN_SZ];
    end
  end

  // Pick the first asserted request after the last winner, wrapping round.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    win_valid = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      cand = GW'(idx);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

  // State register; reset wins even in the middle of a frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode for the grant / handshake sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ser_rdy && win_valid) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!ser_rdy) begin
          next_state = WAIT_DONE;
        end else if (cnt == '0) begin
          next_state = IDLE;
        end
      end
      WAIT_DONE: begin
        if (ser_rdy) begin
          next_state = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Registered outputs, rotating pointer and the shared down-counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack      <= '0;
      ser_data <= '0;
      grant_id <= '0;
      err      <= 1'b0;
      ptr      <= GW'(N_CH - 1);
      cnt      <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (ser_rdy && win_valid) begin
            ser_data     <= words[win_id];
            grant_id     <= win_id;
            ptr          <= win_id;
            ack[win_id]  <= 1'b1;
          end
        end
        ISSUE: begin
          cnt <= CW'(TIMEOUT - 1);
        end
        WAIT_BUSY: begin
          if (ser_rdy) begin
            if (cnt == '0) begin
              err <= 1'b1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        WAIT_DONE: begin
          if (ser_rdy) begin
            cnt <= CW'(GAP_LOAD);
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign ser_nd = (state == ISSUE);

endmodule

// File: tb/tb_serializer_arbiter.sv
// Directed bench for serializer_arbiter with a behavioural serializer stub
// that can respond normally, hold ready low, or leave ready stuck high.
module tb_serializer_arbiter;

  localparam int N_CH    = 4;
  localparam int TXN_SZ  = 8;
  localparam int GAP     = 3;
  localparam int TMO     = 4;
  localparam int FRAME   = 11;
  localparam int MAXWAIT = 300;

  localparam int STUB_NORMAL   = 0;
  localparam int STUB_HOLD_LOW = 1;
  localparam int STUB_STUCK    = 2;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [N_CH-1:0]        req   = '0;
  logic [N_CH*TXN_SZ-1:0] data  = '0;
  logic [N_CH-1:0]        ack;
  logic [TXN_SZ-1:0]      ser_data;
  logic                   ser_nd;
  logic                   ser_rdy = 1'b1;
  logic [1:0]             grant_id;
  logic                   busy;
  logic                   err;

  int tests = 0;
  int fails = 0;

  int          stub_mode = STUB_NORMAL;
  int          stub_cnt  = 0;
  logic [7:0]  cap_word  = '0;

  int   cycle      = 0;
  int   rise_cycle = 0;
  int   last_gap   = 0;
  int   nd_count   = 0;
  logic prev_rdy   = 1'b1;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [1:0]  exp_id;
    logic [7:0]  exp_word;
  } vec_t;

  vec_t vecs [9];

  serializer_arbiter #(
    .N_CH       (N_CH),
    .TXN_SZ     (TXN_SZ),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .ser_data (ser_data),
    .ser_nd   (ser_nd),
    .ser_rdy  (ser_rdy),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err)
  );

  always #5 clock = ~clock;

  // Serializer stub: latches the word one clock after new-data, then stays
  // busy for a frame before raising ready again.
  always @(negedge clock) begin
    if (reset) begin
      stub_cnt = 0;
      ser_rdy  = (stub_mode != STUB_HOLD_LOW);
    end else if (stub_mode == STUB_HOLD_LOW) begin
      stub_cnt = 0;
      ser_rdy  = 1'b0;
    end else if (stub_mode == STUB_STUCK) begin
      stub_cnt = 0;
      ser_rdy  = 1'b1;
    end else if (stub_cnt == 0) begin
      ser_rdy = 1'b1;
      if (ser_nd) stub_cnt = 1;
    end else if (stub_cnt == 1) begin
      cap_word = ser_data;
      ser_rdy  = 1'b0;
      stub_cnt = 2;
    end else if (stub_cnt < FRAME + 1) begin
      stub_cnt = stub_cnt + 1;
    end else begin
      ser_rdy  = 1'b1;
      stub_cnt = 0;
    end
  end

  // Per-cycle monitor: counts new-data pulses and the spacing from the last
  // ready rise to each pulse.
  always begin
    @(posedge clock);
    #3;
    cycle = cycle + 1;
    if (ser_rdy && !prev_rdy) rise_cycle = cycle;
    prev_rdy = ser_rdy;
    if (ser_nd) begin
      nd_count = nd_count + 1;
      last_gap = cycle - rise_cycle;
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    while (ack == '0 && n < MAXWAIT) begin
      tick();
      n++;
    end
    if (ack == '0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: no ack within %0d cycles", name, MAXWAIT);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < MAXWAIT) begin
      tick();
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: still busy after %0d cycles", name, MAXWAIT);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    string tag;
    tag  = $sformatf("vec%0d", idx);
    req  = v.req;
    data = v.data;
    wait_ack(tag);
    check_output({tag, "_ack"},      32'(ack),      32'(4'b0001 << v.exp_id));
    check_output({tag, "_grant_id"}, 32'(grant_id), 32'(v.exp_id));
    check_output({tag, "_ser_data"}, 32'(ser_data), 32'(v.exp_word));
    check_output({tag, "_ser_nd"},   32'(ser_nd),   32'd1);
    req = '0;
    tick();
    check_output({tag, "_ack_pulse"}, 32'(ack),    32'd0);
    check_output({tag, "_nd_pulse"},  32'(ser_nd), 32'd0);
    wait_idle(tag);
    check_output({tag, "_captured"}, 32'(cap_word), 32'(v.exp_word));
  endtask

  initial begin
    logic [1:0] rr_order [5];
    logic [7:0] rr_word  [5];
    int         nd_before;
    int         n;
    bit         saw_ack;

    vecs[0] = '{4'b0100, 32'h00A5_0000, 2'd2, 8'hA5};
    vecs[1] = '{4'b1111, 32'h4433_2211, 2'd3, 8'h44};
    vecs[2] = '{4'b1111, 32'h4433_2211, 2'd0, 8'h11};
    vecs[3] = '{4'b1111, 32'h4433_2211, 2'd1, 8'h22};
    vecs[4] = '{4'b1111, 32'h4433_2211, 2'd2, 8'h33};
    vecs[5] = '{4'b0011, 32'h4433_2211, 2'd0, 8'h11};
    vecs[6] = '{4'b0011, 32'h4433_2211, 2'd1, 8'h22};
    vecs[7] = '{4'b1000, 32'h4433_2211, 2'd3, 8'h44};
    vecs[8] = '{4'b1001, 32'h4433_2211, 2'd0, 8'h11};

    rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_word  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    // Reset values
    reset = 1'b1;
    repeat (3) tick();
    check_output("rst_ack",      32'(ack),      32'd0);
    check_output("rst_ser_data", 32'(ser_data), 32'd0);
    check_output("rst_ser_nd",   32'(ser_nd),   32'd0);
    check_output("rst_grant_id", 32'(grant_id), 32'd0);
    check_output("rst_busy",     32'(busy),     32'd0);
    check_output("rst_err",      32'(err),      32'd0);
    reset = 1'b0;
    tick();

    // Table of single grants exercising the rotating pointer
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i], i);
    end

    // Serializer not ready: request must wait, then win the cycle after the rise
    stub_mode = STUB_HOLD_LOW;
    req  = 4'b0010;
    data = 32'h4433_2211;
    saw_ack = 1'b0;
    repeat (8) begin
      tick();
      if (ack != '0) saw_ack = 1'b1;
    end
    check_output("hold_no_ack",  32'(saw_ack), 32'd0);
    check_output("hold_no_busy", 32'(busy),    32'd0);
    stub_mode = STUB_NORMAL;
    n = 0;
    while (!ser_rdy && n < 5) begin
      tick();
      n++;
    end
    check_output("hold_rdy_rose",    32'(ser_rdy),  32'd1);
    check_output("hold_ack_at_rise", 32'(ack),      32'(4'b0010));
    check_output("hold_grant_id",    32'(grant_id), 32'd1);
    req = '0;
    wait_idle("hold");

    // Ready stuck high: single pulse, timeout error after TIMEOUT cycles
    stub_mode = STUB_STUCK;
    req = 4'b0001;
    wait_ack("tmo");
    check_output("tmo_ack", 32'(ack), 32'(4'b0001));
    nd_before = nd_count;
    req = '0;
    repeat (4) tick();
    check_output("tmo_err_not_yet", 32'(err),  32'd0);
    check_output("tmo_busy_wait",   32'(busy), 32'd1);
    tick();
    check_output("tmo_err_set",   32'(err),                  32'd1);
    check_output("tmo_idle",      32'(busy),                 32'd0);
    check_output("tmo_nd_once",   32'(nd_count - nd_before), 32'd1);
    stub_mode = STUB_NORMAL;
    tick();
    apply_stimulus('{4'b0100, 32'h4433_2211, 2'd2, 8'h33}, 9);
    check_output("tmo_err_sticky", 32'(err), 32'd1);

    // Reset in the middle of a frame, all requests held high
    req  = 4'b1111;
    data = 32'h4433_2211;
    wait_ack("midrst");
    check_output("midrst_grant_id_pre", 32'(grant_id), 32'd3);
    n = 0;
    while (ser_rdy && n < 10) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check_output("midrst_in_frame", 32'(ser_rdy), 32'd0);
    reset = 1'b1;
    tick();
    check_output("midrst_busy",     32'(busy),     32'd0);
    check_output("midrst_ser_nd",   32'(ser_nd),   32'd0);
    check_output("midrst_ack",      32'(ack),      32'd0);
    check_output("midrst_grant_id", 32'(grant_id), 32'd0);
    check_output("midrst_err",      32'(err),      32'd0);
    reset = 1'b0;

    // Requests held high: strict rotation with the inter-frame gap honoured
    for (int g = 0; g < 5; g++) begin
      wait_ack($sformatf("rr%0d", g));
      check_output($sformatf("rr%0d_grant_id", g), 32'(grant_id), 32'(rr_order[g]));
      check_output($sformatf("rr%0d_ser_data", g), 32'(ser_data), 32'(rr_word[g]));
      tick();
      if (g > 0) begin
        check_output($sformatf("rr%0d_gap", g), 32'(last_gap), 32'(GAP + 1));
      end
    end
    req = '0;
    wait_idle("rr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serializer_arbiter.md
Name: serializer_arbiter

Overview:
Round-robin transmit scheduler that shares one serializer between N_CH requesters. It accepts one word per grant and holds it in a register. It issues a single new-data pulse to the serializer, then tracks the serializer's ready line through busy and back to idle. An optional inter-frame gap and a handshake-timeout error flag are included. It sits between the command/telemetry word sources and the serial line driver.

Parameters:
N_CH, 4, number of requesters (>=1)
TXN_SZ, 8, word width; must match the serializer's transaction size
GAP_CYCLES, 0, minimum idle clocks between serializer ready returning high and the next grant
TIMEOUT, 4, clocks to wait for serializer ready to drop after the new-data pulse before flagging an error (>=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  N_CH  per-channel request; level, sampled only in IDLE
data  in  N_CH*TXN_SZ  per-channel word; channel i occupies bits [i*TXN_SZ +: TXN_SZ]
ack  out  N_CH  one-cycle pulse on the granted channel; word has been captured
ser_data  out  TXN_SZ  word to the serializer
ser_nd  out  1  new-data pulse to the serializer
ser_rdy  in  1  serializer ready (high = idle)
grant_id  out  GW  index of the channel last granted; GW = max(1, clog2(N_CH))
busy  out  1  high in every state except IDLE
err  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- All outputs are registered except busy and ser_nd, which are decoded from state.
- Reset values: ack=0, ser_data=0, ser_nd=0, grant_id=0, busy=0, err=0, state=IDLE, round-robin pointer=N_CH-1 so channel 0 has first priority.
- Synchronous reset has priority in every state, including mid-frame. The serializer shares the same reset.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: leaves only if ser_rdy=1 and req is nonzero.
  - Winner = first asserted req searching from pointer+1 upward, wrapping modulo N_CH.
  - At the clock edge: hold register <= winner's data; grant_id <= winner; pointer <= winner; ack[winner] <= 1 for one cycle; state <= ISSUE.
- ISSUE: exactly one cycle.
  - ser_nd=1, ack[winner]=1, ser_data = hold register.
  - Next state is WAIT_BUSY; the timeout counter is loaded with TIMEOUT-1.
- ser_data stability: held constant from ISSUE until the next grant. The serializer captures the word presented during its new-data cycle one clock later, so ser_data must not change in the cycle after ISSUE.
- WAIT_BUSY:
  - ser_rdy=0 -> WAIT_DONE.
  - Otherwise decrement the counter; at counter==0 with ser_rdy still 1 -> set err, go to IDLE. The word is dropped and no retry is made.
- WAIT_DONE: ser_rdy=1 -> GAP if GAP_CYCLES>0, else IDLE. There is no timeout: a frame is TXN_SZ+3 bit-clocks plus a latch cycle.
- GAP: counter loaded with GAP_CYCLES-1 on entry; -> IDLE when it reaches 0.
- Latency: req seen in IDLE at cycle t -> ack and ser_nd at t+1. Minimum request-to-request spacing = frame length + 2 + GAP_CYCLES.
- Requester rules:
  - Must keep data stable while req is high.
  - Must deassert req, or present the next word, in the cycle after ack.
  - A req that stays high after ack is treated as a new request at the next IDLE.
- Arbitration:
  - A req dropped before a grant is lost without error.
  - Requests arriving in non-IDLE states wait.
  - Simultaneous requests are resolved strictly by the rotating pointer, so there is no starvation: any asserted req is granted within N_CH grants.
- N_CH=1: the pointer is always 0, and grant_id is 1 bit and always 0.

Test Plan:
- N_CH=4, single req[2] with data word 0xA5 -> ack=0b0100 for one cycle; ser_nd single pulse with ser_data=0xA5; serializer output bits 1,1,0,1,0,0,1,0,1,0,0; grant_id=2.
- All four req held high, distinct words 0x11/0x22/0x33/0x44 -> grant order 0,1,2,3,0; each ser_nd preceded by a ser_rdy high edge; no overlapping frames.
- ser_rdy forced low by a stub, req[1] asserted -> no ack until ser_rdy rises; ack[1] appears on the cycle after the rise.
- GAP_CYCLES=3, two back-to-back requests -> at least 3 idle cycles between ser_rdy rising and the next ack/ser_nd.
- Stub ser_rdy stuck at 1, req[0] -> ser_nd pulses once; err=1 after TIMEOUT cycles; FSM returns to IDLE; err stays 1 through further grants until reset.
- Reset asserted in WAIT_DONE mid-frame -> next cycle busy=0, ser_nd=0, ack=0, grant_id=0, err=0; with all req high, the first grant after reset goes to channel 0.
